// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result select, load type and FSM state.
package wb_pkg;

  // Result source select; the reserved value 3 is treated as ALU.
  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_LINK = 2'd2;

  // Load type; undefined values behave as a full-word load.
  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    WAIT  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of memory-stage input, memory response, register-file write and bypass signals
// for the writeback stage. master = surroundings driving the stage, slave = the stage.
interface writeback_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [RADDR_W-1:0] in_rd;
  logic               in_regwrite;
  logic [1:0]         in_sel;
  logic [XLEN-1:0]    in_alu;
  logic [XLEN-1:0]    in_link;
  logic [2:0]         in_ldtype;
  logic [1:0]         in_addr_lo;
  logic               mem_rvalid;
  logic [XLEN-1:0]    mem_rdata;
  logic [RADDR_W-1:0] rf_waddr;
  logic               rf_wen;
  logic [XLEN-1:0]    rf_wdata;
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_addr;
  logic [XLEN-1:0]    fwd_data;
  logic               busy_load;
  logic               ld_err;

  modport master (
    output in_valid, in_rd, in_regwrite, in_sel, in_alu, in_link, in_ldtype, in_addr_lo,
    output mem_rvalid, mem_rdata,
    input  in_ready, rf_waddr, rf_wen, rf_wdata, fwd_valid, fwd_addr, fwd_data,
    input  busy_load, ld_err
  );

  modport slave (
    input  in_valid, in_rd, in_regwrite, in_sel, in_alu, in_link, in_ldtype, in_addr_lo,
    input  mem_rvalid, mem_rdata,
    output in_ready, rf_waddr, rf_wen, rf_wdata, fwd_valid, fwd_addr, fwd_data,
    output busy_load, ld_err
  );
endinterface

// File: rtl/load_extract.sv
// Combinational load data extraction: picks byte/halfword from the raw memory word and
// sign- or zero-extends it. Sub-word support is built only when WB_SUBWORD_EN is defined;
// otherwise the raw word passes through untouched.
module load_extract
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      ldtype_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);

`ifdef WB_SUBWORD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection then extension by load type.
  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    // Halfword loads ignore the low offset bit.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ldtype_i)
      LD_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
      LD_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end
`else
  // Type and offset are irrelevant without sub-word support.
  logic unused_sel;
  assign unused_sel = ^{ldtype_i, addr_lo_i};

  // Every load returns the raw word.
  always_comb begin
    data_o = rdata_i;
  end
`endif

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data when needed, then
// drives the register-file write port and the execute-stage bypass bus.
// Optional sub-word load extraction is enabled by defining WB_SUBWORD_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  writeback_stage_if.slave  bus
);

  wb_state_e          state_q, state_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               regwrite_q, regwrite_d;
  logic [1:0]         sel_q, sel_d;
  logic [XLEN-1:0]    alu_q, alu_d;
  logic [XLEN-1:0]    link_q, link_d;
  logic [2:0]         ldtype_q, ldtype_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic [XLEN-1:0]    load_q, load_d;
  logic               ld_err_q, ld_err_d;

  logic [XLEN-1:0]    ld_data;
  logic [XLEN-1:0]    result;
  logic               full;
  logic               wen;

  // Extraction uses the type and offset latched when the load was accepted.
  load_extract #(
    .XLEN (XLEN)
  ) u_load_extract (
    .rdata_i  (bus.mem_rdata),
    .ldtype_i (ldtype_q),
    .addr_lo_i(addr_lo_q),
    .data_o   (ld_data)
  );

  // Next-state: accept in EMPTY/FULL, wait for the memory response in WAIT.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    sel_d      = sel_q;
    alu_d      = alu_q;
    link_d     = link_q;
    ldtype_d   = ldtype_q;
    addr_lo_d  = addr_lo_q;
    load_d     = load_q;
    // A response outside WAIT has no owner; flag it until reset.
    ld_err_d   = ld_err_q | (bus.mem_rvalid && (state_q != WAIT));

    case (state_q)
      EMPTY, FULL: begin
        if (bus.in_valid) begin
          rd_d       = bus.in_rd;
          regwrite_d = bus.in_regwrite;
          sel_d      = bus.in_sel;
          alu_d      = bus.in_alu;
          link_d     = bus.in_link;
          ldtype_d   = bus.in_ldtype;
          addr_lo_d  = bus.in_addr_lo;
          state_d    = (bus.in_sel == SEL_LOAD) ? WAIT : FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          load_d  = ld_data;
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Stage registers; reset discards any pending load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      sel_q      <= SEL_ALU;
      alu_q      <= '0;
      link_q     <= '0;
      ldtype_q   <= LD_W;
      addr_lo_q  <= '0;
      load_q     <= '0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      sel_q      <= sel_d;
      alu_q      <= alu_d;
      link_q     <= link_d;
      ldtype_q   <= ldtype_d;
      addr_lo_q  <= addr_lo_d;
      load_q     <= load_d;
      ld_err_q   <= ld_err_q ? 1'b1 : ld_err_d;
    end
  end

  // Outputs decoded from registered state; write/bypass buses read zero unless retiring.
  always_comb begin
    full = (state_q == FULL);
    case (sel_q)
      SEL_LOAD: result = load_q;
      SEL_LINK: result = link_q;
      default:  result = alu_q;
    endcase
    wen = full && regwrite_q && (rd_q != '0);
  end

  assign bus.in_ready  = (state_q != WAIT);
  assign bus.busy_load = (state_q == WAIT);
  assign bus.rf_wen    = wen;
  assign bus.rf_waddr  = full ? rd_q : '0;
  assign bus.rf_wdata  = full ? result : '0;
  assign bus.fwd_valid = full && wen;
  assign bus.fwd_addr  = bus.rf_waddr;
  assign bus.fwd_data  = bus.rf_wdata;
  assign bus.ld_err    = ld_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; expectations are hand-computed constants.
module tb_writeback_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  writeback_stage_if #(.XLEN(32), .RADDR_W(5)) bus ();

  writeback_stage #(
    .XLEN   (32),
    .RADDR_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_rd       = '0;
    bus.in_regwrite = 1'b0;
    bus.in_sel      = 2'd0;
    bus.in_alu      = '0;
    bus.in_link     = '0;
    bus.in_ldtype   = 3'd0;
    bus.in_addr_lo  = 2'd0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  // Load with a 3-cycle memory delay, then check the retired value.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] ldt,
                         input logic [1:0] alo, input logic [31:0] rdata,
                         input logic [31:0] exp);
    bus.in_valid    = 1'b1;
    bus.in_rd       = rd;
    bus.in_regwrite = 1'b1;
    bus.in_sel      = 2'd1;
    bus.in_ldtype   = ldt;
    bus.in_addr_lo  = alo;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_ready_wait"}, {31'd0, bus.in_ready}, 32'd0);
      chk({tag, "_busy_wait"}, {31'd0, bus.busy_load}, 32'd1);
      chk({tag, "_wen_wait"}, {31'd0, bus.rf_wen}, 32'd0);
      if (i == 2) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
      end
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    chk({tag, "_wen"}, {31'd0, bus.rf_wen}, 32'd1);
    chk({tag, "_waddr"}, {27'd0, bus.rf_waddr}, {27'd0, rd});
    chk({tag, "_wdata"}, bus.rf_wdata, exp);
    chk({tag, "_busy_done"}, {31'd0, bus.busy_load}, 32'd0);
    tick();
    chk({tag, "_wen_after"}, {31'd0, bus.rf_wen}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    #1;
    chk("rst_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("rst_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_fwd", {31'd0, bus.fwd_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_load}, 32'd0);
    chk("rst_lderr", {31'd0, bus.ld_err}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // ALU retire
    bus.in_valid    = 1'b1;
    bus.in_rd       = 5'd5;
    bus.in_regwrite = 1'b1;
    bus.in_sel      = 2'd0;
    bus.in_alu      = 32'h1234_5678;
    tick();
    bus.in_valid = 1'b0;
    chk("alu_wen", {31'd0, bus.rf_wen}, 32'd1);
    chk("alu_waddr", {27'd0, bus.rf_waddr}, 32'd5);
    chk("alu_wdata", bus.rf_wdata, 32'h1234_5678);
    chk("alu_fwd_valid", {31'd0, bus.fwd_valid}, 32'd1);
    chk("alu_fwd_addr", {27'd0, bus.fwd_addr}, 32'd5);
    chk("alu_fwd_data", bus.fwd_data, 32'h1234_5678);
    tick();
    chk("alu_wen_after", {31'd0, bus.rf_wen}, 32'd0);
    chk("alu_fwd_after", {31'd0, bus.fwd_valid}, 32'd0);

    // rd=0 never written
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd0;
    bus.in_alu   = 32'hFFFF_FFFF;
    tick();
    bus.in_valid = 1'b0;
    chk("rd0_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("rd0_fwd", {31'd0, bus.fwd_valid}, 32'd0);
    tick();

    // regwrite=0 never written
    bus.in_valid    = 1'b1;
    bus.in_rd       = 5'd9;
    bus.in_regwrite = 1'b0;
    tick();
    bus.in_valid    = 1'b0;
    bus.in_regwrite = 1'b1;
    chk("norw_wen", {31'd0, bus.rf_wen}, 32'd0);
    tick();

    // Link and reserved select
    bus.in_valid = 1'b1;
    bus.in_rd    = 5'd31;
    bus.in_sel   = 2'd2;
    bus.in_alu   = 32'hAAAA_0000;
    bus.in_link  = 32'h0000_1008;
    tick();
    bus.in_sel = 2'd3;
    bus.in_rd  = 5'd4;
    chk("link_wdata", bus.rf_wdata, 32'h0000_1008);
    chk("link_waddr", {27'd0, bus.rf_waddr}, 32'd31);
    tick();
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    chk("rsv_wdata", bus.rf_wdata, 32'hAAAA_0000);
    tick();

    // Loads
`ifdef WB_SUBWORD_EN
    do_load("lb", 5'd7, 3'd3, 2'd2, 32'h0080_0000, 32'hFFFF_FF80);
    do_load("lbu", 5'd8, 3'd4, 2'd2, 32'h0080_0000, 32'h0000_0080);
    do_load("lhu", 5'd10, 3'd2, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("lh", 5'd11, 3'd1, 2'd1, 32'h1234_8001, 32'hFFFF_8001);
`else
    do_load("lb", 5'd7, 3'd3, 2'd2, 32'h0080_0000, 32'h0080_0000);
    do_load("lbu", 5'd8, 3'd4, 2'd2, 32'h0080_0000, 32'h0080_0000);
    do_load("lhu", 5'd10, 3'd2, 2'd2, 32'hBEEF_0000, 32'hBEEF_0000);
    do_load("lh", 5'd11, 3'd1, 2'd1, 32'h1234_8001, 32'h1234_8001);
`endif
    do_load("lw", 5'd12, 3'd0, 2'd3, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Back-to-back ALU instructions
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      bus.in_rd  = 5'(i);
      bus.in_alu = 32'h100 + 32'(i);
      tick();
      if (i == 3) bus.in_valid = 1'b0;
      chk($sformatf("b2b%0d_wen", i), {31'd0, bus.rf_wen}, 32'd1);
      chk($sformatf("b2b%0d_waddr", i), {27'd0, bus.rf_waddr}, 32'(i));
      chk($sformatf("b2b%0d_wdata", i), bus.rf_wdata, 32'h100 + 32'(i));
    end
    tick();
    chk("b2b_end_wen", {31'd0, bus.rf_wen}, 32'd0);

    // Stray response in EMPTY
    chk("pre_stray_lderr", {31'd0, bus.ld_err}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("stray_lderr", {31'd0, bus.ld_err}, 32'd1);
    chk("stray_wen", {31'd0, bus.rf_wen}, 32'd0);
    tick();
    tick();
    chk("stray_lderr_held", {31'd0, bus.ld_err}, 32'd1);

    // Reset while waiting on a load
    bus.in_valid  = 1'b1;
    bus.in_rd     = 5'd6;
    bus.in_sel    = 2'd1;
    bus.in_ldtype = 3'd0;
    tick();
    bus.in_valid = 1'b0;
    chk("rw_busy", {31'd0, bus.busy_load}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rw_busy_rst", {31'd0, bus.busy_load}, 32'd0);
    chk("rw_ready_rst", {31'd0, bus.in_ready}, 32'd1);
    chk("rw_wen_rst", {31'd0, bus.rf_wen}, 32'd0);
    chk("rw_lderr_rst", {31'd0, bus.ld_err}, 32'd0);
    chk("rw_wdata_rst", bus.rf_wdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("rw_late_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("rw_late_lderr", {31'd0, bus.ld_err}, 32'd1);
    chk("rw_late_busy", {31'd0, bus.busy_load}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
